// File: rtl/alarm_ringer_if.sv
// -----------------------------------------------------------------------------
// alarm_ringer_if
// Groups the alarm ringer's control inputs and user-facing status outputs.
//   master : the side driving the controls (clock counter, buttons, enable)
//   slave  : the ringer itself
// Signals:
//   enable, alarm_in, snooze_btn, stop_btn      master -> slave
//   buzzer, ringing, snoozing, snooze_count,    slave -> master
//   missed
// -----------------------------------------------------------------------------
interface alarm_ringer_if #(
   parameter int unsigned MAX_SNOOZE = 3
);
   localparam int unsigned SCW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

   logic           enable;
   logic           alarm_in;
   logic           snooze_btn;
   logic           stop_btn;
   logic           buzzer;
   logic           ringing;
   logic           snoozing;
   logic [SCW-1:0] snooze_count;
   logic           missed;

   modport master (
      output enable, alarm_in, snooze_btn, stop_btn,
      input  buzzer, ringing, snoozing, snooze_count, missed
   );

   modport slave (
      input  enable, alarm_in, snooze_btn, stop_btn,
      output buzzer, ringing, snoozing, snooze_count, missed
   );
endinterface

// File: rtl/alarm_ringer.sv
// -----------------------------------------------------------------------------
// alarm_ringer
// Turns the clock counter's alarm match pulse into a ring sequence: gated
// buzzer pattern, bounded snoozes, stop button and auto-timeout with a sticky
// "missed" flag.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : alarm_ringer_if.slave
//            enable       alarm armed; low forces IDLE
//            alarm_in     match pulse (same clock domain), rising-edge detected
//            snooze_btn   async level pin, synchronised + edge detected
//            stop_btn     async level pin, synchronised + edge detected
//            buzzer       beep waveform, 0 outside RING
//            ringing      state is RING
//            snoozing     state is SNOOZE
//            snooze_count snoozes used in the current alarm event
//            missed       sticky: a RING timed out unanswered
// -----------------------------------------------------------------------------
module alarm_ringer #(
   parameter int unsigned RING_TIMEOUT  = 16,
   parameter int unsigned SNOOZE_CYCLES = 8,
   parameter int unsigned BEEP_HALF     = 2,
   parameter int unsigned MAX_SNOOZE    = 3
) (
   input logic           clk,
   input logic           rst_n,
   alarm_ringer_if.slave bus
);

   localparam int unsigned RTW = (RING_TIMEOUT  > 1) ? $clog2(RING_TIMEOUT)  : 1;
   localparam int unsigned STW = (SNOOZE_CYCLES > 1) ? $clog2(SNOOZE_CYCLES) : 1;
   localparam int unsigned BCW = (BEEP_HALF     > 1) ? $clog2(BEEP_HALF)     : 1;
   localparam int unsigned SCW = (MAX_SNOOZE    > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

   localparam logic [RTW-1:0] RING_LAST = RTW'(RING_TIMEOUT - 1);
   localparam logic [STW-1:0] SNZ_LAST  = STW'(SNOOZE_CYCLES - 1);
   localparam logic [BCW-1:0] BEEP_LAST = BCW'(BEEP_HALF - 1);
   localparam logic [SCW-1:0] SNZ_MAX   = SCW'(MAX_SNOOZE);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1,
      ST_SNOOZE = 2'd2
   } state_e;

   // Synchroniser / edge-detect flops
   logic snz_s1_q, snz_s1_d, snz_s2_q, snz_s2_d, snz_prev_q, snz_prev_d;
   logic stp_s1_q, stp_s1_d, stp_s2_q, stp_s2_d, stp_prev_q, stp_prev_d;
   logic alarm_q, alarm_d;

   // FSM and datapath flops
   state_e         state_q, state_d;
   logic [RTW-1:0] ring_tmr_q, ring_tmr_d;
   logic [STW-1:0] snz_tmr_q, snz_tmr_d;
   logic [BCW-1:0] beep_cnt_q, beep_cnt_d;
   logic           buzzer_q, buzzer_d;
   logic           ringing_q, ringing_d;
   logic           snoozing_q, snoozing_d;
   logic [SCW-1:0] snooze_count_q, snooze_count_d;
   logic           missed_q, missed_d;

   logic snz_evt, stp_evt, alarm_evt;

   // Two-flop synchronisers plus a previous-value flop for edge detection
   always_comb begin
      snz_s1_d   = bus.snooze_btn;
      snz_s2_d   = snz_s1_q;
      snz_prev_d = snz_s2_q;
      stp_s1_d   = bus.stop_btn;
      stp_s2_d   = stp_s1_q;
      stp_prev_d = stp_s2_q;
      alarm_d    = bus.alarm_in;
   end

   // A held button or a held alarm_in produces a single event
   assign snz_evt   = snz_s2_q & ~snz_prev_q;
   assign stp_evt   = stp_s2_q & ~stp_prev_q;
   assign alarm_evt = bus.alarm_in & ~alarm_q;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snz_s1_q       <= 1'b0;
         snz_s2_q       <= 1'b0;
         snz_prev_q     <= 1'b0;
         stp_s1_q       <= 1'b0;
         stp_s2_q       <= 1'b0;
         stp_prev_q     <= 1'b0;
         alarm_q        <= 1'b0;
         state_q        <= ST_IDLE;
         ring_tmr_q     <= '0;
         snz_tmr_q      <= '0;
         beep_cnt_q     <= '0;
         buzzer_q       <= 1'b0;
         ringing_q      <= 1'b0;
         snoozing_q     <= 1'b0;
         snooze_count_q <= '0;
         missed_q       <= 1'b0;
      end else begin
         snz_s1_q       <= snz_s1_d;
         snz_s2_q       <= snz_s2_d;
         snz_prev_q     <= snz_prev_d;
         stp_s1_q       <= stp_s1_d;
         stp_s2_q       <= stp_s2_d;
         stp_prev_q     <= stp_prev_d;
         alarm_q        <= alarm_d;
         state_q        <= state_d;
         ring_tmr_q     <= ring_tmr_d;
         snz_tmr_q      <= snz_tmr_d;
         beep_cnt_q     <= beep_cnt_d;
         buzzer_q       <= buzzer_d;
         ringing_q      <= ringing_d;
         snoozing_q     <= snoozing_d;
         snooze_count_q <= snooze_count_d;
         missed_q       <= missed_d;
      end
   end

   // Next-state and output logic; priority: enable=0 > stop > timeout > snooze > alarm
   always_comb begin
      state_d        = state_q;
      ring_tmr_d     = ring_tmr_q;
      snz_tmr_d      = snz_tmr_q;
      beep_cnt_d     = beep_cnt_q;
      buzzer_d       = buzzer_q;
      snooze_count_d = snooze_count_q;
      missed_d       = missed_q;

      // Stop acknowledges a missed alarm in any state
      if (stp_evt) begin
         missed_d = 1'b0;
      end

      if (!bus.enable) begin
         state_d        = ST_IDLE;
         ring_tmr_d     = '0;
         snz_tmr_d      = '0;
         beep_cnt_d     = '0;
         buzzer_d       = 1'b0;
         snooze_count_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               buzzer_d = 1'b0;
               if (!stp_evt && alarm_evt) begin
                  state_d    = ST_RING;
                  ring_tmr_d = '0;
                  beep_cnt_d = '0;
                  buzzer_d   = 1'b1;
               end
            end

            ST_RING: begin
               if (stp_evt) begin
                  state_d        = ST_IDLE;
                  ring_tmr_d     = '0;
                  beep_cnt_d     = '0;
                  buzzer_d       = 1'b0;
                  snooze_count_d = '0;
               end else if (ring_tmr_q == RING_LAST) begin
                  state_d        = ST_IDLE;
                  ring_tmr_d     = '0;
                  beep_cnt_d     = '0;
                  buzzer_d       = 1'b0;
                  snooze_count_d = '0;
                  missed_d       = 1'b1;
               end else if (snz_evt && (snooze_count_q < SNZ_MAX)) begin
                  state_d        = ST_SNOOZE;
                  snz_tmr_d      = '0;
                  buzzer_d       = 1'b0;
                  snooze_count_d = snooze_count_q + SCW'(1);
               end else begin
                  ring_tmr_d = ring_tmr_q + RTW'(1);
                  // Square wave: BEEP_HALF cycles high, BEEP_HALF cycles low
                  if (beep_cnt_q == BEEP_LAST) begin
                     beep_cnt_d = '0;
                     buzzer_d   = ~buzzer_q;
                  end else begin
                     beep_cnt_d = beep_cnt_q + BCW'(1);
                  end
               end
            end

            ST_SNOOZE: begin
               buzzer_d = 1'b0;
               if (stp_evt) begin
                  state_d        = ST_IDLE;
                  snz_tmr_d      = '0;
                  snooze_count_d = '0;
               end else if (snz_tmr_q == SNZ_LAST) begin
                  // Re-enter RING with a fresh timer and beep phase
                  state_d    = ST_RING;
                  ring_tmr_d = '0;
                  beep_cnt_d = '0;
                  buzzer_d   = 1'b1;
               end else begin
                  snz_tmr_d = snz_tmr_q + STW'(1);
               end
            end

            default: begin
               state_d        = ST_IDLE;
               buzzer_d       = 1'b0;
               snooze_count_d = '0;
            end
         endcase
      end

      ringing_d  = (state_d == ST_RING);
      snoozing_d = (state_d == ST_SNOOZE);
   end

   assign bus.buzzer       = buzzer_q;
   assign bus.ringing      = ringing_q;
   assign bus.snoozing     = snoozing_q;
   assign bus.snooze_count = snooze_count_q;
   assign bus.missed       = missed_q;

endmodule
